// File: rtl/posit_pkg.sv
// Shared posit definitions: width helper, special-pattern helpers and the
// decoded-field bundle exchanged between the extraction and encode blocks.
package posit_pkg;

  localparam int POSIT_N  = 8;
  localparam int POSIT_ES = 3;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic logic [63:0] nar_pattern(input int n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic logic [63:0] maxpos_mag(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] minpos_mag(input int n);
    return (n > 1) ? 64'd1 : 64'd0;
  endfunction

  localparam int POSIT_RS = log2(POSIT_N);
  localparam int POSIT_MW = POSIT_N - POSIT_ES + 3;

  typedef struct packed {
    logic                     sign;
    logic signed [POSIT_RS:0] regime;
    logic [POSIT_ES-1:0]      exponent;
    logic [POSIT_MW-1:0]      mantissa;
    logic                     zero;
    logic                     nar;
  } posit_fields_t;

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even on the kept magnitude bits, then clamp so the result
// never rounds to zero and never carries into the NaR pattern.
module posit_round_rne
  import posit_pkg::*;
#(
  parameter int N = POSIT_N
) (
  input  logic [N-2:0] kept,
  input  logic         guard,
  input  logic         sticky,
  output logic [N-2:0] mag
);

  localparam int MW = N - 1;
  localparam logic [N-2:0] MAX_MAG = MW'(maxpos_mag(N));
  localparam logic [N-2:0] MIN_MAG = MW'(minpos_mag(N));

  logic         round_up;
  logic [N-1:0] sum;

  assign round_up = guard && (sticky || kept[0]);
  assign sum      = {1'b0, kept} + N'(round_up);

  // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mag = sum[N-2:0];
    if (sum[N-1]) begin
      mag = MAX_MAG;
    end else if (sum[N-2:0] == '0) begin
      mag = MIN_MAG;
    end
  end

endmodule

// File: rtl/posit_encode_pipe.sv
// Three-stage posit encoder: S1 captures fields, S2 builds regime/exponent/fraction
// and rounds, S3 applies sign and special cases. One global stall holds all stages.
module posit_encode_pipe
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int RS = log2(N)
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic               InValid,
  output logic               InReady,
  input  logic               InZero,
  input  logic               InNaR,
  input  logic               Sign,
  input  logic signed [RS:0] RegimeValue,
  input  logic [ES-1:0]      Exponent,
  input  logic [N-ES+2:0]    Mantissa,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [N-1:0]       Posit
);

  localparam int FW    = N - ES + 2;     // fraction bits below the hidden one
  localparam int TW    = ES + FW;        // exponent + fraction tail
  localparam int SW    = (N - 1) + TW;   // regime window followed by the tail
  localparam int K_MIN = -(N - 1);
  localparam int K_MAX = N - 2;
  localparam logic [N-1:0] NAR = N'(nar_pattern(N));

  logic advance;

  // The only back-pressure source is a held output word.
  assign advance = !(OutValid && !OutReady);
  assign InReady = advance;

  // ---------------- S1: capture ----------------
  logic          s1_valid;
  posit_fields_t s1;

  // NOTE: all state, data included, is reset with non-blocking assignments; the pipe is shallow and Posit must read 0 in reset.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (advance) begin
      s1_valid <= InValid;
      if (InValid) begin
        s1 <= '{sign: Sign, regime: RegimeValue, exponent: Exponent,
                mantissa: Mantissa, zero: InZero, nar: InNaR};
      end
    end
  end

  // ---------------- S2: regime, assemble, round ----------------
  int            k_clamped;
  int            run;
  int            regime_len;
  logic [N-2:0]  regime_bits;
  logic [SW-1:0] assembled;
  logic [N-2:0]  kept;
  logic          guard;
  logic          sticky;
  logic [N-2:0]  rounded;

  always_comb begin
    k_clamped = int'(s1.regime);
    if (k_clamped < K_MIN) k_clamped = K_MIN;
    else if (k_clamped > K_MAX) k_clamped = K_MAX;
    run        = (k_clamped >= 0) ? k_clamped + 1 : -k_clamped;
    // The terminator is dropped once the run alone fills the magnitude.
    regime_len = (run >= N - 1) ? N - 1 : run + 1;
    regime_bits = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (i < run) regime_bits[N-2-i] = (k_clamped >= 0);
      else if (i == run) regime_bits[N-2-i] = (k_clamped < 0);
    end
    assembled = {regime_bits, {TW{1'b0}}}
              | (SW'({s1.exponent, s1.mantissa[FW-1:0]}) << (N - 1 - regime_len));
  end

  assign kept   = assembled[SW-1 -: N-1];
  assign guard  = assembled[SW-N];
  assign sticky = |assembled[SW-N-1:0];

  posit_round_rne #(.N(N)) u_round (
    .kept   (kept),
    .guard  (guard),
    .sticky (sticky),
    .mag    (rounded)
  );

  logic         s2_valid;
  logic         s2_sign;
  logic         s2_zero;
  logic         s2_nar;
  logic [N-2:0] s2_mag;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_nar   <= 1'b0;
      s2_mag   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1.sign;
      s2_zero  <= s1.zero;
      s2_nar   <= s1.nar;
      s2_mag   <= rounded;
    end
  end

  // ---------------- S3: sign and special cases ----------------
  logic [N-1:0] posit_next;

  always_comb begin
    posit_next = {1'b0, s2_mag};
    if (s2_nar) posit_next = NAR;
    else if (s2_zero) posit_next = '0;
    else if (s2_sign) posit_next = -{1'b0, s2_mag};
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      OutValid <= 1'b0;
      Posit    <= '0;
    end else if (advance) begin
      OutValid <= s2_valid;
      if (s2_valid) Posit <= posit_next;
    end
  end

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Self-checking bench for posit_encode_pipe: directed vectors, a stall scenario,
// randomized traffic against a bit-string reference model, and a mid-flight reset.
module tb_posit_encode_pipe;

  localparam int N  = 8;
  localparam int ES = 3;
  localparam int RS = 3;
  localparam int MW = N - ES + 3;
  localparam int FW = N - ES + 2;

  logic               Clock;
  logic               nReset;
  logic               InValid;
  logic               InReady;
  logic               InZero;
  logic               InNaR;
  logic               Sign;
  logic signed [RS:0] RegimeValue;
  logic [ES-1:0]      Exponent;
  logic [MW-1:0]      Mantissa;
  logic               OutValid;
  logic               OutReady;
  logic [N-1:0]       Posit;

  int n_checks;
  int n_errors;
  logic [N-1:0] exp_q[$];

  posit_encode_pipe #(.N(N), .ES(ES), .RS(RS)) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .InValid     (InValid),
    .InReady     (InReady),
    .InZero      (InZero),
    .InNaR       (InNaR),
    .Sign        (Sign),
    .RegimeValue (RegimeValue),
    .Exponent    (Exponent),
    .Mantissa    (Mantissa),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .Posit       (Posit)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Reference: build the posit bit string literally, then round and saturate.
  function automatic logic [N-1:0] model(input logic s, input int k, input logic [ES-1:0] e,
                                         input logic [MW-1:0] m, input logic z, input logic nar);
    bit bits[$];
    int run;
    int mag;
    bit g;
    bit st;
    if (nar) return 8'h80;
    if (z) return 8'h00;
    if (k < -(N - 1)) k = -(N - 1);
    if (k > N - 2) k = N - 2;
    run = (k >= 0) ? k + 1 : -k;
    for (int i = 0; i < run; i++) bits.push_back(k >= 0);
    if (run < N - 1) bits.push_back(k < 0);
    for (int i = ES - 1; i >= 0; i--) bits.push_back(e[i]);
    for (int i = FW - 1; i >= 0; i--) bits.push_back(m[i]);
    mag = 0;
    for (int i = 0; i < N - 1; i++) mag = mag * 2 + int'(bits[i]);
    g  = bits[N-1];
    st = 0;
    for (int i = N; i < bits.size(); i++) st |= bits[i];
    if (g && (st || (mag % 2 == 1))) mag++;
    if (mag > 2 ** (N - 1) - 1) mag = 2 ** (N - 1) - 1;
    if (mag < 1) mag = 1;
    return s ? N'(2 ** N - mag) : N'(mag);
  endfunction

  task automatic send_one(input string tag, input logic s, input int k, input logic [ES-1:0] e,
                          input logic [MW-1:0] m, input logic z, input logic nar,
                          input logic [N-1:0] want);
    int lat;
    Sign        = s;
    RegimeValue = k[RS:0];
    Exponent    = e;
    Mantissa    = m;
    InZero      = z;
    InNaR       = nar;
    InValid     = 1'b1;
    OutReady    = 1'b1;
    @(negedge Clock);
    check({tag, "_rdy"}, InReady, 1);
    @(posedge Clock); #1;
    InValid = 1'b0;
    InZero  = 1'b0;
    InNaR   = 1'b0;
    lat = 0;
    do begin
      @(negedge Clock);
      lat++;
    end while (!OutValid && lat < 10);
    check({tag, "_lat"}, lat, 3);
    check(tag, Posit, want);
    @(posedge Clock); #1;
  endtask

  task automatic run_stream(input string tag, input int n_items, input bit rand_in,
                            input bit rand_out, input int stall_lo, input int stall_hi,
                            output int stall_cycles);
    int sent;
    int got;
    int cyc;
    int extra;
    bit have;
    bit prev_stall;
    logic [N-1:0] prev_posit;
    logic [31:0] r;
    sent = 0; got = 0; cyc = 0; have = 0; prev_stall = 0; prev_posit = '0;
    stall_cycles = 0;
    exp_q.delete();
    while (got < n_items && cyc < 20 * n_items + 50) begin
      if (!have && sent < n_items) begin
        r           = $urandom;
        Sign        = r[0];
        RegimeValue = r[4:1];
        Exponent    = r[7:5];
        Mantissa    = {1'b1, r[14:8]};
        InZero      = (r[19:16] == 4'd0);
        InNaR       = (r[23:20] == 4'd0);
        have        = 1;
      end
      InValid  = have && (!rand_in || $urandom_range(0, 3) != 0);
      OutReady = rand_out ? ($urandom_range(0, 2) != 0) : !(cyc >= stall_lo && cyc <= stall_hi);
      @(negedge Clock);
      check({tag, "_inrdy"}, InReady, !(OutValid && !OutReady));
      if (prev_stall) begin
        check({tag, "_hold_v"}, OutValid, 1);
        check({tag, "_hold"}, Posit, prev_posit);
      end
      if (OutValid && !OutReady) stall_cycles++;
      if (OutValid && OutReady) begin
        check({tag, "_unexpected"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check(tag, Posit, exp_q.pop_front());
          got++;
        end
      end
      if (InValid && InReady) begin
        exp_q.push_back(model(Sign, int'(RegimeValue), Exponent, Mantissa, InZero, InNaR));
        sent++;
        have = 0;
      end
      prev_stall = OutValid && !OutReady;
      prev_posit = Posit;
      @(posedge Clock); #1;
      cyc++;
    end
    check({tag, "_count"}, got, n_items);
    InValid  = 1'b0;
    InZero   = 1'b0;
    InNaR    = 1'b0;
    OutReady = 1'b1;
    extra = 0;
    repeat (5) begin
      @(negedge Clock);
      if (OutValid) extra++;
      @(posedge Clock); #1;
    end
    check({tag, "_extra"}, extra, 0);
  endtask

  initial begin
    int stalls;
    int flushed;
    n_checks = 0;
    n_errors = 0;
    nReset = 1'b0; InValid = 1'b0; InZero = 1'b0; InNaR = 1'b0; Sign = 1'b0;
    RegimeValue = '0; Exponent = '0; Mantissa = '0; OutReady = 1'b1;

    #3;
    check("rst_valid", OutValid, 0);
    check("rst_posit", Posit, 0);
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    @(posedge Clock); #1;
    check("rst_inrdy", InReady, 1);

    send_one("pos_k0",       0,  0, 3'b100, 8'h80, 0, 0, 8'h50);
    send_one("neg_k0",       1,  0, 3'b100, 8'h80, 0, 0, 8'hB0);
    send_one("k_m1",         0, -1, 3'b000, 8'h80, 0, 0, 8'h20);
    send_one("k6",           0,  6, 3'b000, 8'h80, 0, 0, 8'h7F);
    send_one("k7_sat",       0,  7, 3'b000, 8'h80, 0, 0, 8'h7F);
    send_one("k_m7",         0, -7, 3'b000, 8'h80, 0, 0, 8'h01);
    send_one("k_m8_sat",     0, -8, 3'b000, 8'h80, 0, 0, 8'h01);
    send_one("rne_tie_even", 0,  0, 3'b101, 8'hD0, 0, 0, 8'h56);
    send_one("rne_above",    0,  0, 3'b101, 8'hD8, 0, 0, 8'h57);
    send_one("rne_carry",    0,  0, 3'b101, 8'hF0, 0, 0, 8'h58);
    send_one("zero",         1,  3, 3'b101, 8'hC3, 1, 0, 8'h00);
    send_one("nar",          0,  2, 3'b011, 8'hA5, 0, 1, 8'h80);
    send_one("nar_zero",     1,  1, 3'b001, 8'h99, 1, 1, 8'h80);

    run_stream("stall", 6, 0, 0, 5, 8, stalls);
    check("stall_cycles", stalls, 4);
    run_stream("rand", 300, 1, 1, -1, -1, stalls);

    // Three items back to back: the first reaches the output, two are in flight.
    OutReady = 1'b1;
    Sign = 1'b0; RegimeValue = 4'sd0; Exponent = 3'b100; Mantissa = 8'h80; InValid = 1'b1;
    @(posedge Clock); #1;
    RegimeValue = -4'sd1; Exponent = 3'b000;
    @(posedge Clock); #1;
    RegimeValue = 4'sd6;
    @(posedge Clock); #1;
    InValid = 1'b0;
    check("mid_pre_valid", OutValid, 1);
    check("mid_pre_posit", Posit, 8'h50);
    #2 nReset = 1'b0;
    #1;
    check("mid_rst_valid", OutValid, 0);
    check("mid_rst_posit", Posit, 0);
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    @(posedge Clock); #1;
    flushed = 0;
    repeat (6) begin
      @(negedge Clock);
      if (OutValid) flushed++;
      @(posedge Clock); #1;
    end
    check("mid_flushed", flushed, 0);
    send_one("post_rst", 0, -1, 3'b000, 8'h80, 0, 0, 8'h20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/posit_encode_pipe.md
Name: posit_encode_pipe

Overview:
Pipelined posit encoder: packs decoded posit fields (sign, regime value, exponent, mantissa) back into an N-bit posit word, with round-to-nearest-even and saturation.
It is the inverse of the field-extraction stage and sits at the output of the posit arithmetic datapath, after normalisation.
It has three register stages with a valid/ready handshake on both sides.

Parameters:
N, 8, posit word width
ES, 3, exponent field width
RS, log2(N), regime value magnitude width; the regime port is signed RS+1 bits

Ports:
Clock  input  1  rising-edge clock
nReset  input  1  asynchronous active-low reset
InValid  input  1  input fields valid
InReady  output  1  block can accept input this cycle
InZero  input  1  encode exact zero; other fields ignored
InNaR  input  1  encode NaR; has priority over InZero
Sign  input  1  sign of value (1 = negative)
RegimeValue  input  RS+1  signed regime k
Exponent  input  ES  unsigned exponent
Mantissa  input  N-ES+3  bit [N-ES+2] is the hidden 1; the lower N-ES+2 bits are the fraction
OutValid  output  1  Posit valid
OutReady  input  1  downstream accepts Posit
Posit  output  N  encoded posit

Behaviour:
- Reset (async on nReset low): OutValid=0, Posit=0, all stage valid flags=0. InReady=1 once nReset is high.
- Transfer rules:
  - Input transfer on InValid&&InReady.
  - Output transfer on OutValid&&OutReady.
  - Global stall: InReady = !(OutValid && !OutReady).
  - While stalled, every stage register and Posit hold their values. Bubbles are not compacted.
- Latency: exactly 3 cycles from input transfer to OutValid with no stall. Throughput: 1 per cycle.
- S1 (regime):
  - Register the fields and flags.
  - Clamp k to [-(N-1), N-2]; out-of-range values saturate (maxpos/minpos).
  - Regime run length: k>=0 gives k+1 ones then a 0; k<0 gives -k zeros then a 1.
  - The terminator bit is dropped when the run fills N-1 bits.
- S2 (assemble and round):
  - Form string {regime, Exponent, fraction} and keep the top N-1 bits as the magnitude.
  - G = the next bit; St = OR of all remaining bits.
  - Round up iff G && (St || LSB). The carry may propagate into the exponent and regime; this is a valid posit encoding.
  - Clamp the magnitude to [1, 2^(N-1)-1]: no rounding to zero, no overflow into NaR.
- S3 (sign):
  - Posit = {1'b0, mag} if Sign=0; otherwise the two's complement of {1'b0, mag}.
  - InNaR gives 1 followed by N-1 zeros. InZero gives all zeros. The special cases bypass rounding and Sign.
- Reset mid-operation: in-flight data is discarded; no output is produced for it.
- Simultaneous input and output transfer in the same cycle is legal and sustains full rate.

Decomposition:
- Shared package posit_pkg:
  - log2 function
  - constants NAR_PATTERN(N) and MAXPOS/MINPOS helpers
  - typedef posit_fields_t: sign, regime, exponent, mantissa, zero, nar
  - This typedef is also used by the extraction block.
- One natural sub-module: posit_round_rne (combinational). Inputs are the kept bits, G and St; outputs are the rounded magnitude and the saturation clamp. Instantiated in S2.

Test Plan (all N=8, ES=3, OutReady=1 unless stated):
- Sign=0, k=0, Exp=3'b100, Mantissa=8'h80 -> Posit=8'h50 three cycles after the input transfer. Same fields with Sign=1 -> 8'hB0.
- k=-1, Exp=0, Mantissa=8'h80 -> 8'h20. k=6 -> 8'h7F. k=7 (out of range) -> 8'h7F. k=-7 -> 8'h01. k=-8 -> 8'h01 (never 8'h00).
- Rounding, all with k=0, Exp=3'b101:
  - Mantissa=8'hD0 (tie, even LSB) -> 8'h56.
  - Mantissa=8'hD8 (above half) -> 8'h57.
  - Mantissa=8'hF0 (tie, odd LSB, carry into exponent) -> 8'h58.
- InZero=1 -> 8'h00. InNaR=1 -> 8'h80. InNaR=1 with InZero=1 -> 8'h80.
- Back-to-back inputs for 6 cycles, OutReady=0 for 4 cycles mid-stream:
  - InReady drops while OutValid&&!OutReady.
  - Posit holds its value while stalled.
  - All 6 results emerge in order with none lost or duplicated.
- Pulse nReset low while 2 items are in flight: OutValid=0 and Posit=0 immediately (asynchronously). After release, the first new input produces OutValid exactly 3 cycles later.
